state_invariant_monitor: RTL and testbench
==========================================

# state_invariant_monitor

Parametrised, pipelined invariant checker for the carry-save adder output stage. Each valid operand pair (final carry and sum vectors plus the stage reset) produces an expected result. The monitor delays that result through a configurable-depth pipeline and compares it against the result bus LATENCY cycles later. It reports a registered per-check ok, keeps sticky failure state, counts mismatches, and captures the first failing expected/actual pair for debug.

## Interface

Parameters:
- WIDTH, 64, datapath width of operands and result.
- LATENCY, 1, cycles from an operand sample to its result on res; legal range 1..16.
- INV_MODE, 0, expected-result function: 0 gives ~final_c + ~final_s; 1 gives final_c + final_s.
- CNT_W, 16, width of the mismatch counter.

Ports:
- clk, in, 1, the single clock; all state updates on its rising edge.
- reset_n, in, 1, asynchronous active-low reset.
- en, in, 1, accept new operand samples when high.
- clr, in, 1, synchronous clear of the pipeline, flags, counter and capture.
- vld_in, in, 1, the operand sample this cycle is valid.
- final_c, in, WIDTH, carry vector.
- final_s, in, WIDTH, sum vector.
- stage_reset, in, 1, stage reset qualifier; forces the expected result to 0.
- res, in, WIDTH, result bus, sampled LATENCY cycles after its operands.
- chk_vld, out, 1, a comparison completed last cycle.
- ok, out, 1, result of the last comparison: 1 on match.
- fail, out, 1, sticky: at least one mismatch since reset or clr.
- err_cnt, out, CNT_W, saturating mismatch count.
- first_exp, out, WIDTH, expected value at the first mismatch.
- first_act, out, WIDTH, actual value at the first mismatch.
- state, out, 2, FSM state: 0 IDLE, 1 RUN, 2 FAIL.

## Operation

- Expected value:
  - If stage_reset is high, the expected value is 0.
  - Otherwise it is computed per INV_MODE, modulo 2^WIDTH, with the carry-out discarded.
- Sample push:
  - A sample is pushed into the delay line when vld_in=1 and en=1.
  - Each delay-line entry holds a valid bit and the expected value.
- Delay line:
  - The line is LATENCY entries deep and shifts every cycle.
  - An entry reaching the head is compared to res that cycle.
  - An empty head produces no comparison.
- Disable and drain:
  - en=0 blocks new pushes only.
  - Samples already in flight still drain and are still checked.
- FSM:
  - Reset state is IDLE.
  - IDLE→RUN when en=1.
  - RUN→IDLE when en=0 and the delay line is empty.
  - RUN or IDLE→FAIL on any mismatch.
  - FAIL is held until clr. clr moves FAIL or RUN to IDLE.
- In FAIL:
  - Checking continues.
  - ok and err_cnt keep updating.
  - first_exp and first_act are frozen.
- First-failure capture: first_exp and first_act load only on the mismatch that sets fail.
- err_cnt increments by 1 per mismatch and saturates at 2^CNT_W−1. It never wraps.
- clr:
  - Invalidates every delay-line entry.
  - Zeroes fail, err_cnt, first_exp and first_act; sets ok=1 and chk_vld=0.
  - Has priority over a same-cycle push or compare: both are discarded.
- reset_n low, even mid-check:
  - Gives the same effect as clr, applied asynchronously.
  - Outputs reset to: chk_vld=0, ok=1, fail=0, err_cnt=0, first_exp=0, first_act=0, state=IDLE.

## Timing

- Sample accepted at cycle t.
- The comparison against res happens at cycle t+LATENCY.
- chk_vld, ok, fail, err_cnt, the captures and state are updated at the t+LATENCY edge. They are visible during cycle t+LATENCY+1.
- Back-to-back samples are supported: one comparison per cycle, no bubbles.
- After reset_n deasserts or clr, the first comparison can occur no earlier than LATENCY cycles after the first accepted sample. There are no false checks during warm-up.
- The mismatch that sets fail is visible in the same cycle as its ok=0 and its err_cnt increment.

## Test plan

All scenarios use WIDTH=64 unless stated.

- Match, LATENCY=1, INV_MODE=0:
  - Stimulus: final_c=0, final_s=0, stage_reset=0, vld_in=1 at t; res=0xFFFF_FFFF_FFFF_FFFE at t+1.
  - Required: chk_vld=1, ok=1, fail=0 at t+2.
- Stage reset:
  - Stimulus: stage_reset=1, final_c=0x5, final_s=0x7; res=0 one LATENCY later.
  - Required: ok=1.
  - Stimulus repeated with res=0x1.
  - Required: ok=0, fail=1, err_cnt=1, first_exp=0, first_act=0x1, state=FAIL.
- LATENCY=4, INV_MODE=1:
  - Stimulus: 8 back-to-back samples with final_c=i and final_s=2i, and correct res=3i.
  - Required: chk_vld high for 8 consecutive cycles starting at t+5, all ok=1.
  - Stimulus: corrupt only sample 5.
  - Required: exactly one ok=0, first_exp=15.
- Wrap-around, INV_MODE=1:
  - Stimulus: final_c=0xFFFF_FFFF_FFFF_FFFF, final_s=1, res=0.
  - Required: ok=1, because the carry is discarded.
- Saturation and clear, CNT_W=2:
  - Stimulus: 5 mismatches.
  - Required: err_cnt=3 and held; first_* still hold the first failure.
  - Stimulus: clr.
  - Required: all outputs return to reset values, state=IDLE.
- Mid-operation reset and drain:
  - Stimulus: LATENCY=3; push 2 samples, then en=0.
  - Required: both are still checked, then state=IDLE.
  - Stimulus: repeat, with reset_n pulsed low while the samples are in flight.
  - Required: no chk_vld afterwards, outputs at reset values.

Source files
------------

// File: rtl/state_invariant_monitor.sv
// state_invariant_monitor: checks a result bus against the expected carry-save output of operands sampled LATENCY cycles earlier.
// Latency: compare happens LATENCY cycles after a sample is accepted; its outcome is registered and visible one cycle later.
// Backpressure: none; en only gates new samples, samples already in flight always drain and are checked.
module state_invariant_monitor #(
  parameter int WIDTH    = 64,
  parameter int LATENCY  = 1,
  parameter int INV_MODE = 0,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             clr,
  input  logic             vld_in,
  input  logic [WIDTH-1:0] final_c,
  input  logic [WIDTH-1:0] final_s,
  input  logic             stage_reset,
  input  logic [WIDTH-1:0] res,
  output logic             chk_vld,
  output logic             ok,
  output logic             fail,
  output logic [CNT_W-1:0] err_cnt,
  output logic [WIDTH-1:0] first_exp,
  output logic [WIDTH-1:0] first_act,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FAIL = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Delay line: one valid bit and one expected value per stage; last stage is the head.
  logic [LATENCY-1:0] line_vld_q;
  logic [WIDTH-1:0]   line_exp_q [LATENCY];

  logic               push;
  logic [WIDTH-1:0]   sample_exp;
  logic               head_vld;
  logic [WIDTH-1:0]   head_exp;
  logic               mismatch;
  logic               line_empty;

  logic               chk_vld_q;
  logic               ok_q;
  logic               fail_q;
  logic [CNT_W-1:0]   err_cnt_q;
  logic [WIDTH-1:0]   first_exp_q;
  logic [WIDTH-1:0]   first_act_q;
  state_e             state_q;

  assign push       = vld_in & en;
  assign head_vld   = line_vld_q[LATENCY-1];
  assign head_exp   = line_exp_q[LATENCY-1];
  assign mismatch   = head_vld && (head_exp != res);
  // Includes the head being compared this cycle, so RUN drops to IDLE only once the line has fully drained.
  assign line_empty = ~|line_vld_q;

  // Expected result of the current operand sample; carry-out beyond WIDTH is dropped by the sum width.
  always_comb begin
    sample_exp = '0;
    if (!stage_reset) begin
      if (INV_MODE == 1) begin
        sample_exp = final_c + final_s;
      end else begin
        sample_exp = ~final_c + ~final_s;
      end
    end
  end

  // Shift the delay line every cycle; clr drops every in-flight sample and any same-cycle push.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      line_vld_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        line_exp_q[i] <= '0;
      end
    end else if (clr) begin
      line_vld_q <= '0;
    end else begin
      line_vld_q[0] <= push;
      line_exp_q[0] <= sample_exp;
      for (int i = 1; i < LATENCY; i++) begin
        line_vld_q[i] <= line_vld_q[i-1];
        line_exp_q[i] <= line_exp_q[i-1];
      end
    end
  end

  // Control FSM with registered check outputs, sticky failure, saturating count and first-failure capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chk_vld_q   <= 1'b0;
      ok_q        <= 1'b1;
      fail_q      <= 1'b0;
      err_cnt_q   <= '0;
      first_exp_q <= '0;
      first_act_q <= '0;
      state_q     <= ST_IDLE;
    end else if (clr) begin
      chk_vld_q   <= 1'b0;
      ok_q        <= 1'b1;
      fail_q      <= 1'b0;
      err_cnt_q   <= '0;
      first_exp_q <= '0;
      first_act_q <= '0;
      state_q     <= ST_IDLE;
    end else begin
      chk_vld_q <= head_vld;
      if (head_vld) begin
        ok_q <= ~mismatch;
      end
      if (mismatch) begin
        fail_q <= 1'b1;
        if (err_cnt_q != CNT_MAX) begin
          err_cnt_q <= err_cnt_q + CNT_W'(1);
        end
        // Capture only the mismatch that first raises fail; later ones leave the debug pair frozen.
        if (!fail_q) begin
          first_exp_q <= head_exp;
          first_act_q <= res;
        end
      end
      case (state_q)
        ST_IDLE: begin
          if (mismatch) begin
            state_q <= ST_FAIL;
          end else if (en) begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (mismatch) begin
            state_q <= ST_FAIL;
          end else if (!en && line_empty) begin
            state_q <= ST_IDLE;
          end
        end
        ST_FAIL: begin
          state_q <= ST_FAIL;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign chk_vld   = chk_vld_q;
  assign ok        = ok_q;
  assign fail      = fail_q;
  assign err_cnt   = err_cnt_q;
  assign first_exp = first_exp_q;
  assign first_act = first_act_q;
  assign state     = state_q;

endmodule

// File: tb/tb_state_invariant_monitor.sv
// tb_state_invariant_monitor: three monitor instances (different LATENCY/INV_MODE/CNT_W) share operand stimulus,
// each gets its own result bus; a due-cycle scoreboard predicts every output each cycle.
// Directed scenarios pin the scoreboard with literal values, then a randomized phase runs.
module tb_state_invariant_monitor;
  localparam int W  = 64;
  localparam int NI = 3;
  localparam int LATS  [NI] = '{1, 4, 3};
  localparam int MODES [NI] = '{0, 1, 1};
  localparam int CWS   [NI] = '{16, 2, 16};

  logic          clk;
  logic          reset_n;
  logic          en;
  logic          clr;
  logic          vld_in;
  logic [W-1:0]  final_c;
  logic [W-1:0]  final_s;
  logic          stage_reset;
  logic [W-1:0]  res      [NI];

  logic [NI-1:0] chk_vld_w;
  logic [NI-1:0] ok_w;
  logic [NI-1:0] fail_w;
  logic [15:0]   cnt_w    [NI];
  logic [W-1:0]  fexp_w   [NI];
  logic [W-1:0]  fact_w   [NI];
  logic [1:0]    st_w     [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [CWS[g]-1:0] cnt;
    state_invariant_monitor #(
      .WIDTH(W), .LATENCY(LATS[g]), .INV_MODE(MODES[g]), .CNT_W(CWS[g])
    ) u_dut (
      .clk(clk), .reset_n(reset_n), .en(en), .clr(clr), .vld_in(vld_in),
      .final_c(final_c), .final_s(final_s), .stage_reset(stage_reset), .res(res[g]),
      .chk_vld(chk_vld_w[g]), .ok(ok_w[g]), .fail(fail_w[g]), .err_cnt(cnt),
      .first_exp(fexp_w[g]), .first_act(fact_w[g]), .state(st_w[g])
    );
    assign cnt_w[g] = 16'(cnt);
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard: samples are filed under the cycle in which they are due for comparison.
  int            ncyc;
  bit            sv       [NI][32];
  logic [W-1:0]  se       [NI][32];
  bit            m_chk    [NI];
  bit            m_ok     [NI];
  bit            m_fail   [NI];
  int            m_cnt    [NI];
  int            m_state  [NI];
  logic [W-1:0]  m_fexp   [NI];
  logic [W-1:0]  m_fact   [NI];
  int            corrupt_at  [NI];
  bit            corrupt_all [NI];
  bit            rnd_err;
  int            n_chk;
  int            n_pass;

  task automatic cmp(string nm, int k, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d: got %0h expected %0h (cycle %0d)", nm, k, act, exp, ncyc);
  endtask

  function automatic logic [W-1:0] exp_of(int k);
    if (stage_reset) return '0;
    if (MODES[k] == 1) return final_c + final_s;
    return ~final_c + ~final_s;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      for (int j = 0; j < 32; j++) sv[k][j] = 1'b0;
      m_chk[k] = 1'b0; m_ok[k] = 1'b1; m_fail[k] = 1'b0; m_cnt[k] = 0;
      m_state[k] = 0; m_fexp[k] = '0; m_fact[k] = '0;
    end
  endtask

  // Advance the scoreboard across one rising edge using the inputs of the cycle that just ended.
  task automatic model_step();
    for (int k = 0; k < NI; k++) begin
      int  occ;
      int  slot;
      bit  cmpv;
      bit  mis;
      occ  = 0;
      slot = ncyc % 32;
      for (int j = 0; j < 32; j++) if (sv[k][j]) occ++;
      if (clr) begin
        for (int j = 0; j < 32; j++) sv[k][j] = 1'b0;
        m_chk[k] = 1'b0; m_ok[k] = 1'b1; m_fail[k] = 1'b0; m_cnt[k] = 0;
        m_state[k] = 0; m_fexp[k] = '0; m_fact[k] = '0;
      end else begin
        cmpv = sv[k][slot];
        mis  = cmpv && (se[k][slot] != res[k]);
        sv[k][slot] = 1'b0;
        m_chk[k] = cmpv;
        if (cmpv) m_ok[k] = !mis;
        if (mis) begin
          if (!m_fail[k]) begin
            m_fexp[k] = se[k][slot];
            m_fact[k] = res[k];
          end
          m_fail[k] = 1'b1;
          if (m_cnt[k] < (1 << CWS[k]) - 1) m_cnt[k]++;
        end
        if (vld_in && en) begin
          sv[k][(ncyc + LATS[k]) % 32] = 1'b1;
          se[k][(ncyc + LATS[k]) % 32] = exp_of(k);
        end
        if (mis) m_state[k] = 2;
        else if (m_state[k] == 0 && en) m_state[k] = 1;
        else if (m_state[k] == 1 && !en && occ == 0) m_state[k] = 0;
      end
    end
    ncyc++;
  endtask

  task automatic check_all();
    for (int k = 0; k < NI; k++) begin
      cmp("chk_vld",   k, 64'(chk_vld_w[k]), 64'(m_chk[k]));
      cmp("ok",        k, 64'(ok_w[k]),      64'(m_ok[k]));
      cmp("fail",      k, 64'(fail_w[k]),    64'(m_fail[k]));
      cmp("err_cnt",   k, 64'(cnt_w[k]),     64'(m_cnt[k]));
      cmp("first_exp", k, fexp_w[k],         m_fexp[k]);
      cmp("first_act", k, fact_w[k],         m_fact[k]);
      cmp("state",     k, 64'(st_w[k]),      64'(m_state[k]));
    end
  endtask

  // Drive each result bus for the upcoming cycle: the due value (optionally corrupted) or noise.
  task automatic auto_res();
    for (int k = 0; k < NI; k++) begin
      int slot;
      slot = ncyc % 32;
      if (sv[k][slot]) begin
        res[k] = se[k][slot];
        if (ncyc == corrupt_at[k] || corrupt_all[k]) res[k] = res[k] ^ 64'd1;
        else if (rnd_err && $urandom_range(0, 9) == 0) res[k] = res[k] ^ (64'd1 << $urandom_range(0, 63));
      end else begin
        res[k] = {$urandom, $urandom};
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic step();
    auto_res();
    tick();
  endtask

  task automatic do_clr();
    clr = 1'b1; vld_in = 1'b0;
    step();
    clr = 1'b0;
  endtask

  task automatic set_op(bit v, logic [W-1:0] c, logic [W-1:0] s, bit sr);
    vld_in = v; final_c = c; final_s = s; stage_reset = sr;
  endtask

  task automatic pulse_reset();
    #2 reset_n = 1'b0;
    model_reset();
    #1 check_all();
    #1 reset_n = 1'b1;
  endtask

  initial begin
    int p0;
    int nchk_seen;
    int nok_seen;
    int nbad_seen;
    int first_seen;
    n_chk = 0; n_pass = 0; ncyc = 0; rnd_err = 1'b0;
    for (int k = 0; k < NI; k++) begin corrupt_at[k] = -1; corrupt_all[k] = 1'b0; res[k] = '0; end
    reset_n = 1'b0; en = 1'b0; clr = 1'b0;
    set_op(1'b0, '0, '0, 1'b0);
    model_reset();
    @(negedge clk);
    check_all();
    cmp("pin_rst_ok", 0, 64'(ok_w[0]), 64'd1);
    cmp("pin_rst_state", 1, 64'(st_w[1]), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // LATENCY=1, INV_MODE=0 match: ~0 + ~0 = 0xFFFF_FFFF_FFFF_FFFE.
    en = 1'b1;
    set_op(1'b1, '0, '0, 1'b0);
    step();
    set_op(1'b0, '0, '0, 1'b0);
    auto_res();
    res[0] = 64'hFFFF_FFFF_FFFF_FFFE;
    tick();
    cmp("pin_m0_chk", 0, 64'(chk_vld_w[0]), 64'd1);
    cmp("pin_m0_ok", 0, 64'(ok_w[0]), 64'd1);
    cmp("pin_m0_fail", 0, 64'(fail_w[0]), 64'd0);
    for (int i = 0; i < 5; i++) step();

    // Stage reset forces expected 0: match with res=0, then mismatch with res=1.
    do_clr();
    set_op(1'b1, 64'h5, 64'h7, 1'b1);
    step();
    set_op(1'b0, '0, '0, 1'b0);
    auto_res();
    res[0] = 64'h0;
    tick();
    cmp("pin_sr_ok", 0, 64'(ok_w[0]), 64'd1);
    set_op(1'b1, 64'h5, 64'h7, 1'b1);
    step();
    set_op(1'b0, '0, '0, 1'b0);
    auto_res();
    res[0] = 64'h1;
    tick();
    cmp("pin_sr_ok0", 0, 64'(ok_w[0]), 64'd0);
    cmp("pin_sr_fail", 0, 64'(fail_w[0]), 64'd1);
    cmp("pin_sr_cnt", 0, 64'(cnt_w[0]), 64'd1);
    cmp("pin_sr_fexp", 0, fexp_w[0], 64'd0);
    cmp("pin_sr_fact", 0, fact_w[0], 64'd1);
    cmp("pin_sr_state", 0, 64'(st_w[0]), 64'd2);
    for (int i = 0; i < 5; i++) step();

    // LATENCY=4, INV_MODE=1: 8 back-to-back samples, clean then with sample 5 corrupted.
    for (int pass = 0; pass < 2; pass++) begin
      do_clr();
      p0 = ncyc;
      if (pass == 1) corrupt_at[1] = p0 + 5 + 4;
      nchk_seen = 0; nok_seen = 0; nbad_seen = 0; first_seen = -1;
      for (int i = 0; i < 14; i++) begin
        if (i < 8) set_op(1'b1, 64'(i), 64'(2 * i), 1'b0);
        else set_op(1'b0, '0, '0, 1'b0);
        step();
        if (chk_vld_w[1]) begin
          nchk_seen++;
          if (first_seen < 0) first_seen = ncyc - p0;
          if (ok_w[1]) nok_seen++; else nbad_seen++;
        end
      end
      cmp("pin_l4_nchk", 1, 64'(nchk_seen), 64'd8);
      cmp("pin_l4_first", 1, 64'(first_seen), 64'd5);
      cmp("pin_l4_nbad", 1, 64'(nbad_seen), pass == 1 ? 64'd1 : 64'd0);
      if (pass == 1) cmp("pin_l4_fexp", 1, fexp_w[1], 64'd15);
      corrupt_at[1] = -1;
    end

    // Wrap-around in INV_MODE=1: all-ones + 1 = 0 with the carry dropped.
    do_clr();
    set_op(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    step();
    set_op(1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 3; i++) step();
    auto_res();
    res[1] = 64'h0;
    tick();
    cmp("pin_wrap_chk", 1, 64'(chk_vld_w[1]), 64'd1);
    cmp("pin_wrap_ok", 1, 64'(ok_w[1]), 64'd1);

    // Saturation with CNT_W=2: five mismatches, first one is sample 1 (exp 3, act 2).
    do_clr();
    corrupt_all[1] = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      set_op(1'b1, 64'(i), 64'(2 * i), 1'b0);
      step();
    end
    set_op(1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 8; i++) step();
    corrupt_all[1] = 1'b0;
    cmp("pin_sat_cnt", 1, 64'(cnt_w[1]), 64'd3);
    cmp("pin_sat_fexp", 1, fexp_w[1], 64'd3);
    cmp("pin_sat_fact", 1, fact_w[1], 64'd2);
    cmp("pin_sat_state", 1, 64'(st_w[1]), 64'd2);
    do_clr();
    cmp("pin_clr_cnt", 1, 64'(cnt_w[1]), 64'd0);
    cmp("pin_clr_fail", 1, 64'(fail_w[1]), 64'd0);
    cmp("pin_clr_ok", 1, 64'(ok_w[1]), 64'd1);
    cmp("pin_clr_fexp", 1, fexp_w[1], 64'd0);
    cmp("pin_clr_state", 1, 64'(st_w[1]), 64'd0);

    // LATENCY=3 drain after en drops, then the same with reset_n pulsed mid-flight.
    for (int pass = 0; pass < 2; pass++) begin
      do_clr();
      en = 1'b1;
      set_op(1'b1, 64'h10, 64'h20, 1'b0);
      step();
      set_op(1'b1, 64'h11, 64'h22, 1'b0);
      step();
      en = 1'b0;
      set_op(1'b0, '0, '0, 1'b0);
      nchk_seen = 0;
      if (pass == 1) pulse_reset();
      for (int i = 0; i < 5; i++) begin
        step();
        if (chk_vld_w[2]) nchk_seen++;
      end
      cmp("pin_drain_nchk", 2, 64'(nchk_seen), pass == 1 ? 64'd0 : 64'd2);
      cmp("pin_drain_state", 2, 64'(st_w[2]), 64'd0);
      cmp("pin_drain_ok", 2, 64'(ok_w[2]), 64'd1);
    end

    // Randomized phase.
    rnd_err = 1'b1;
    for (int i = 0; i < 2500; i++) begin
      logic [W-1:0] c;
      logic [W-1:0] s;
      case ($urandom_range(0, 3))
        0: c = '1;
        1: c = '0;
        default: c = {$urandom, $urandom};
      endcase
      s = ($urandom_range(0, 3) == 0) ? 64'd1 : {$urandom, $urandom};
      en  = ($urandom_range(0, 9) < 8);
      clr = ($urandom_range(0, 99) < 3);
      set_op($urandom_range(0, 9) < 7, c, s, $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 199) == 0) pulse_reset();
      step();
    end
    clr = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
